// File: rtl/control_botones_vga_pkg.sv
// Shared definitions for the button-to-VGA command block.
//  - button index constants for the four cursor directions
//  - arbiter FSM state encoding
//  - default hold-to-repeat timing
package control_botones_vga_pkg;

  localparam int BTN_ARRIBA = 0;
  localparam int BTN_ABAJO  = 1;
  localparam int BTN_IZQ    = 2;
  localparam int BTN_DER    = 3;

  // Default timing, in clock1k cycles.
  localparam int RETARDO_DEF    = 500;
  localparam int PERIODO_DEF    = 100;
  localparam int ANCHO_CONT_DEF = 10;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } estado_t;

endpackage

// File: rtl/control_botones_vga_if.sv
// Command channel from the button arbiter to the VGA position logic.
//  cmd_valid  master -> slave  a command is being offered
//  cmd_id     master -> slave  index of the button the command belongs to
//  cmd_ready  slave  -> master consumer takes the command this cycle
//
// Handshake: a transfer happens on a rising edge where cmd_valid and cmd_ready
// are both 1. While cmd_valid is 1 the master holds cmd_id stable and does not
// drop cmd_valid until that transfer. cmd_ready while cmd_valid is 0 has no
// effect. cmd_id keeps its last value while cmd_valid is 0.
interface control_botones_vga_if #(
  parameter int ANCHO_ID = 2
);

  logic                cmd_valid;
  logic [ANCHO_ID-1:0] cmd_id;
  logic                cmd_ready;

  modport master (output cmd_valid, output cmd_id, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_id, output cmd_ready);

endinterface

// File: rtl/control_botones_vga_canal_boton.sv
// One button channel: rising-edge detection plus hold-to-repeat.
// Ports:
//  clock1k  in   system clock
//  reset    in   synchronous active-high reset
//  boton    in   debounced button level, synchronous to clock1k
//  evento   out  1 on the rise cycle and on every repeat cycle while held
// The hold counter restarts at the rise; when it reaches RETARDO_REPETICION it
// fires a repeat and reloads to RETARDO_REPETICION-PERIODO_REPETICION, so later
// repeats come every PERIODO_REPETICION cycles. It never wraps.
module canal_boton
  import control_botones_vga_pkg::*;
#(
  parameter int RETARDO_REPETICION = RETARDO_DEF,
  parameter int PERIODO_REPETICION = PERIODO_DEF,
  parameter int ANCHO_CONT         = ANCHO_CONT_DEF
) (
  input  logic clock1k,
  input  logic reset,
  input  logic boton,
  output logic evento
);

  localparam logic [ANCHO_CONT-1:0] RETARDO_C = ANCHO_CONT'(RETARDO_REPETICION);
  localparam logic [ANCHO_CONT-1:0] RECARGA_C =
    ANCHO_CONT'(RETARDO_REPETICION - PERIODO_REPETICION);

  logic                  prev_q, prev_d;
  logic [ANCHO_CONT-1:0] cnt_q, cnt_d;
  logic [ANCHO_CONT-1:0] cnt_inc;
  logic                  flanco;
  logic                  repite;

  always_comb begin
    prev_d  = boton;
    flanco  = boton & ~prev_q;
    repite  = 1'b0;
    cnt_inc = cnt_q + ANCHO_CONT'(1);
    cnt_d   = '0;
    // Low level and the rise cycle both leave the counter at zero.
    if (boton && !flanco) begin
      if (cnt_inc == RETARDO_C) begin
        repite = 1'b1;
        cnt_d  = RECARGA_C;
      end else begin
        cnt_d = cnt_inc;
      end
    end
    evento = flanco | repite;
  end

  always_ff @(posedge clock1k) begin
    if (reset) begin
      prev_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/control_botones_vga.sv
// Turns debounced button levels into one-at-a-time move commands for the VGA
// position logic. Each channel produces press/repeat events, which latch into a
// pending flag; a round-robin arbiter offers one pending channel at a time on
// the command interface.
// Ports:
//  clock1k         in   system clock, rising edge
//  reset           in   synchronous active-high reset
//  botonLimpio     in   N_BOTONES debounced button levels
//  cmd             if   master side of the command channel (cmd_valid/cmd_id/cmd_ready)
//  pendientes      out  N_BOTONES pending-request flags
//  evento_perdido  out  one-cycle pulse when an event lands on an already-pending channel
//  estado_dbg      out  arbiter FSM state
module control_botones_vga
  import control_botones_vga_pkg::*;
#(
  parameter int N_BOTONES          = 4,
  parameter int RETARDO_REPETICION = RETARDO_DEF,
  parameter int PERIODO_REPETICION = PERIODO_DEF,
  parameter int ANCHO_CONT         = ANCHO_CONT_DEF
) (
  input  logic                    clock1k,
  input  logic                    reset,
  input  logic [N_BOTONES-1:0]    botonLimpio,
  control_botones_vga_if.master   cmd,
  output logic [N_BOTONES-1:0]    pendientes,
  output logic                    evento_perdido,
  output estado_t                 estado_dbg
);

  localparam int ANCHO_ID = $clog2(N_BOTONES);

  if (N_BOTONES < 2 || N_BOTONES > 8) begin : g_err_n
    $error("control_botones_vga: N_BOTONES must be 2..8");
  end
  if (PERIODO_REPETICION < 2 || PERIODO_REPETICION > RETARDO_REPETICION) begin : g_err_periodo
    $error("control_botones_vga: PERIODO_REPETICION must be 2..RETARDO_REPETICION");
  end
  if (RETARDO_REPETICION >= (2 ** ANCHO_CONT)) begin : g_err_ancho
    $error("control_botones_vga: ANCHO_CONT too narrow for RETARDO_REPETICION");
  end

  logic [N_BOTONES-1:0] evento;

  for (genvar g = 0; g < N_BOTONES; g++) begin : g_canal
    canal_boton #(
      .RETARDO_REPETICION (RETARDO_REPETICION),
      .PERIODO_REPETICION (PERIODO_REPETICION),
      .ANCHO_CONT         (ANCHO_CONT)
    ) u_canal (
      .clock1k (clock1k),
      .reset   (reset),
      .boton   (botonLimpio[g]),
      .evento  (evento[g])
    );
  end

  estado_t              estado_q, estado_d;
  logic [N_BOTONES-1:0] pending_q, pending_d;
  logic [ANCHO_ID-1:0]  last_grant_q, last_grant_d;
  logic [ANCHO_ID-1:0]  cmd_id_q, cmd_id_d;
  logic                 cmd_valid_q, cmd_valid_d;
  logic                 perdido_q, perdido_d;
  logic [N_BOTONES-1:0] clr;
  logic [ANCHO_ID-1:0]  grant;
  logic                 found;
  int                   tgt;

  // Round robin: visit channels last_grant+1, +2, ... (mod N_BOTONES) and take
  // the first pending one. The inner loop keeps every bit index constant.
  always_comb begin
    found = 1'b0;
    grant = '0;
    tgt   = 0;
    for (int k = 0; k < N_BOTONES; k++) begin
      tgt = int'(last_grant_q) + 1 + k;
      if (tgt >= N_BOTONES) tgt = tgt - N_BOTONES;
      if (tgt >= N_BOTONES) tgt = tgt - N_BOTONES;
      for (int i = 0; i < N_BOTONES; i++) begin
        if (!found && (i == tgt) && pending_q[i]) begin
          found = 1'b1;
          grant = ANCHO_ID'(i);
        end
      end
    end
  end

  always_comb begin
    estado_d     = estado_q;
    cmd_valid_d  = cmd_valid_q;
    cmd_id_d     = cmd_id_q;
    last_grant_d = last_grant_q;
    clr          = '0;
    case (estado_q)
      IDLE: begin
        if (found) begin
          cmd_id_d    = grant;
          cmd_valid_d = 1'b1;
          estado_d    = OFFER;
        end else begin
          cmd_valid_d = 1'b0;
        end
      end
      OFFER: begin
        if (cmd_valid_q && cmd.cmd_ready) begin
          clr[cmd_id_q] = 1'b1;
          last_grant_d  = cmd_id_q;
          cmd_valid_d   = 1'b0;
          estado_d      = IDLE;
        end
      end
      default: begin
        estado_d    = IDLE;
        cmd_valid_d = 1'b0;
      end
    endcase
  end

  // A new event wins over a same-cycle clear, so a press during the handshake
  // is kept as a fresh request. Only an event on a pending, uncleared channel
  // is lost.
  always_comb begin
    pending_d = (pending_q & ~clr) | evento;
    perdido_d = |(evento & pending_q & ~clr);
  end

  always_ff @(posedge clock1k) begin
    if (reset) begin
      estado_q     <= IDLE;
      pending_q    <= '0;
      last_grant_q <= ANCHO_ID'(N_BOTONES - 1);
      cmd_id_q     <= '0;
      cmd_valid_q  <= 1'b0;
      perdido_q    <= 1'b0;
    end else begin
      estado_q     <= estado_d;
      pending_q    <= pending_d;
      last_grant_q <= last_grant_d;
      cmd_id_q     <= cmd_id_d;
      cmd_valid_q  <= cmd_valid_d;
      perdido_q    <= perdido_d;
    end
  end

  assign cmd.cmd_valid  = cmd_valid_q;
  assign cmd.cmd_id     = cmd_id_q;
  assign pendientes     = pending_q;
  assign evento_perdido = perdido_q;
  assign estado_dbg     = estado_q;

endmodule

// File: tb/tb_control_botones_vga.sv
// Bench for control_botones_vga with N_BOTONES=4, RETARDO=5, PERIODO=3.
module tb_control_botones_vga;
  import control_botones_vga_pkg::*;

  localparam int N     = 4;
  localparam int RET   = 5;
  localparam int PER   = 3;
  localparam int ACONT = 4;

  // ---------------- clock / reset ----------------
  logic         clock1k = 1'b0;
  logic         reset;
  logic [N-1:0] botonLimpio;
  logic [N-1:0] pendientes;
  logic         evento_perdido;
  estado_t      estado_dbg;

  control_botones_vga_if #(.ANCHO_ID(2)) cmd_bus ();

  control_botones_vga #(
    .N_BOTONES          (N),
    .RETARDO_REPETICION (RET),
    .PERIODO_REPETICION (PER),
    .ANCHO_CONT         (ACONT)
  ) dut (
    .clock1k        (clock1k),
    .reset          (reset),
    .botonLimpio    (botonLimpio),
    .cmd            (cmd_bus),
    .pendientes     (pendientes),
    .evento_perdido (evento_perdido),
    .estado_dbg     (estado_dbg)
  );

  always #5 clock1k = ~clock1k;

  // ---------------- scoreboard state ----------------
  int         checks = 0;
  int         errors = 0;
  logic [1:0] exp_q[$];
  logic [1:0] got_q[$];

  // ---------------- reference model ----------------
  // Held time per button counted from its rise; a repeat falls on held times
  // RET, RET+PER, RET+2*PER, ...
  bit m_prev[N];
  int m_held[N];
  bit m_pend[N];
  bit m_valid;
  int m_id;
  int m_last;
  bit m_lost;

  function automatic logic [N-1:0] pend_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic model_step(input bit r, input logic [N-1:0] b, input bit rdy);
    bit ev[N];
    bit clr[N];
    bit hs;
    bit nvalid;
    bit got;
    int nid;
    int nlast;
    int c;
    if (r) begin
      for (int i = 0; i < N; i++) begin
        m_prev[i] = 0; m_held[i] = -1; m_pend[i] = 0;
      end
      m_valid = 0; m_id = 0; m_last = N - 1; m_lost = 0;
    end else begin
      hs = m_valid && rdy;
      for (int i = 0; i < N; i++) begin
        clr[i] = hs && (m_id == i);
        if (b[i] && !m_prev[i]) begin
          ev[i] = 1; m_held[i] = 0;
        end else if (b[i]) begin
          m_held[i] = m_held[i] + 1;
          ev[i] = (m_held[i] >= RET) && (((m_held[i] - RET) % PER) == 0);
        end else begin
          ev[i] = 0; m_held[i] = -1;
        end
        m_prev[i] = b[i];
      end
      nvalid = m_valid; nid = m_id; nlast = m_last;
      if (m_valid) begin
        if (rdy) begin
          nvalid = 0; nlast = m_id;
        end
      end else begin
        got = 0;
        for (int k = 1; k <= N; k++) begin
          c = (m_last + k) % N;
          if (!got && m_pend[c]) begin
            got = 1; nvalid = 1; nid = c;
          end
        end
      end
      m_lost = 0;
      for (int i = 0; i < N; i++) begin
        if (ev[i] && m_pend[i] && !clr[i]) m_lost = 1;
        m_pend[i] = (m_pend[i] && !clr[i]) || ev[i];
      end
      m_valid = nvalid; m_id = nid; m_last = nlast;
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge: drive inputs, log any handshake about to happen,
  // advance the model on the rising edge, compare on the next falling edge.
  task automatic ciclo(input bit r, input logic [N-1:0] b, input bit rdy);
    reset             = r;
    botonLimpio       = b;
    cmd_bus.cmd_ready = rdy;
    if (!r && cmd_bus.cmd_valid === 1'b1 && rdy) got_q.push_back(cmd_bus.cmd_id);
    @(posedge clock1k);
    model_step(r, b, rdy);
    @(negedge clock1k);
    check("m_valid", 32'(cmd_bus.cmd_valid), 32'(m_valid));
    check("m_id", 32'(cmd_bus.cmd_id), 32'(m_id));
    check("m_pend", 32'(pendientes), 32'(pend_vec()));
    check("m_perdido", 32'(evento_perdido), 32'(m_lost));
    check("m_estado", 32'(estado_dbg), 32'(m_valid ? OFFER : IDLE));
  endtask

  task automatic compara_cmds(input string name);
    check({name, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      check({name, "_id"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    end
    exp_q.delete();
    got_q.delete();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit         rst;
    logic [3:0] b;
    bit         rdy;
    bit         v;
    logic [1:0] id;
    logic [3:0] p;
    bit         l;
  } vec_t;

  function automatic vec_t mk(bit rst, logic [3:0] b, bit rdy, bit v, logic [1:0] id,
                              logic [3:0] p, bit l);
    vec_t x;
    x.rst = rst; x.b = b; x.rdy = rdy; x.v = v; x.id = id; x.p = p; x.l = l;
    return x;
  endfunction

  vec_t tabla[24];

  initial begin
    // reset, all low
    tabla[0]  = mk(1, 4'b0000, 1, 0, 2'd0, 4'b0000, 0);
    tabla[1]  = mk(1, 4'b0000, 1, 0, 2'd0, 4'b0000, 0);
    tabla[2]  = mk(1, 4'b0000, 1, 0, 2'd0, 4'b0000, 0);
    // single press of button 2, held 2 cycles
    tabla[3]  = mk(0, 4'b0100, 1, 0, 2'd0, 4'b0100, 0);
    tabla[4]  = mk(0, 4'b0100, 1, 1, 2'd2, 4'b0100, 0);
    tabla[5]  = mk(0, 4'b0000, 1, 0, 2'd2, 4'b0000, 0);
    tabla[6]  = mk(0, 4'b0000, 1, 0, 2'd2, 4'b0000, 0);
    // backpressure: button 1 rises twice while pending
    tabla[7]  = mk(0, 4'b0010, 0, 0, 2'd2, 4'b0010, 0);
    tabla[8]  = mk(0, 4'b0000, 0, 1, 2'd1, 4'b0010, 0);
    tabla[9]  = mk(0, 4'b0010, 0, 1, 2'd1, 4'b0010, 1);
    tabla[10] = mk(0, 4'b0000, 0, 1, 2'd1, 4'b0010, 0);
    tabla[11] = mk(0, 4'b0000, 1, 0, 2'd1, 4'b0000, 0);
    tabla[12] = mk(0, 4'b0000, 1, 0, 2'd1, 4'b0000, 0);
    // rise on the handshake cycle keeps the request
    tabla[13] = mk(0, 4'b0010, 0, 0, 2'd1, 4'b0010, 0);
    tabla[14] = mk(0, 4'b0000, 0, 1, 2'd1, 4'b0010, 0);
    tabla[15] = mk(0, 4'b0010, 1, 0, 2'd1, 4'b0010, 0);
    tabla[16] = mk(0, 4'b0000, 0, 1, 2'd1, 4'b0010, 0);
    tabla[17] = mk(0, 4'b0000, 1, 0, 2'd1, 4'b0000, 0);
    tabla[18] = mk(0, 4'b0000, 1, 0, 2'd1, 4'b0000, 0);
    // reset in the middle of an offer
    tabla[19] = mk(0, 4'b1000, 0, 0, 2'd1, 4'b1000, 0);
    tabla[20] = mk(0, 4'b0000, 0, 1, 2'd3, 4'b1000, 0);
    tabla[21] = mk(1, 4'b0000, 0, 0, 2'd0, 4'b0000, 0);
    tabla[22] = mk(0, 4'b0000, 1, 0, 2'd0, 4'b0000, 0);
    tabla[23] = mk(0, 4'b0000, 1, 0, 2'd0, 4'b0000, 0);

    reset             = 1'b1;
    botonLimpio       = '0;
    cmd_bus.cmd_ready = 1'b1;

    for (int k = 0; k < 24; k++) begin
      ciclo(tabla[k].rst, tabla[k].b, tabla[k].rdy);
      check($sformatf("tab%0d_valid", k), 32'(cmd_bus.cmd_valid), 32'(tabla[k].v));
      check($sformatf("tab%0d_id", k), 32'(cmd_bus.cmd_id), 32'(tabla[k].id));
      check($sformatf("tab%0d_pend", k), 32'(pendientes), 32'(tabla[k].p));
      check($sformatf("tab%0d_perdido", k), 32'(evento_perdido), 32'(tabla[k].l));
    end
    got_q.delete();

    // hold-to-repeat: events at rise, +5, +8, +11, +14 -> five commands for id 0
    for (int k = 0; k < 15; k++) ciclo(0, 4'b0001, 1);
    for (int k = 0; k < 8; k++) ciclo(0, 4'b0000, 1);
    repeat (5) exp_q.push_back(2'd0);
    compara_cmds("repeat");

    // round robin from reset (last_grant=3): 0,1,3
    ciclo(1, 4'b0000, 1);
    ciclo(1, 4'b0000, 1);
    ciclo(0, 4'b1011, 1);
    for (int k = 0; k < 8; k++) ciclo(0, 4'b0000, 1);
    exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd3);
    compara_cmds("rr_reset");

    // make last_grant=0, then the same burst gives 1,3,0
    ciclo(0, 4'b0001, 1);
    for (int k = 0; k < 4; k++) ciclo(0, 4'b0000, 1);
    ciclo(0, 4'b1011, 1);
    for (int k = 0; k < 8; k++) ciclo(0, 4'b0000, 1);
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1); exp_q.push_back(2'd3); exp_q.push_back(2'd0);
    compara_cmds("rr_last0");

    // randomized traffic against the model: sticky buttons, random ready, rare reset
    begin
      logic [N-1:0] b;
      bit           rdy;
      bit           r;
      b = '0;
      for (int k = 0; k < 1500; k++) begin
        for (int i = 0; i < N; i++) begin
          if ($urandom_range(0, 5) == 0) b[i] = ~b[i];
        end
        rdy = ($urandom_range(0, 3) != 0);
        r   = ($urandom_range(0, 199) == 0);
        ciclo(r, b, rdy);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
